// File: rtl/hdmi_cfg_pkg.sv
// Shared types for the HDMI transmitter configuration sequencer: FSM states,
// table entry layout and the default ADV7513 power-up register table.
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    WAIT_PWR = 3'd0,
    LOAD     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } cfg_entry_t;

  localparam int ADV7513_ENTRIES = 31;

  // Indices past the end of the table read as zero.
  function automatic cfg_entry_t cfg_table(input logic [5:0] idx);
    logic [15:0] e;
    case (idx)
      6'd0:  e = 16'h4110;
      6'd1:  e = 16'h9803;
      6'd2:  e = 16'h9AE0;
      6'd3:  e = 16'h9C30;
      6'd4:  e = 16'h9D61;
      6'd5:  e = 16'hA2A4;
      6'd6:  e = 16'hA3A4;
      6'd7:  e = 16'hE0D0;
      6'd8:  e = 16'hF900;
      6'd9:  e = 16'h1500;
      6'd10: e = 16'h1630;
      6'd11: e = 16'h1702;
      6'd12: e = 16'h1846;
      6'd13: e = 16'hAF06;
      6'd14: e = 16'h4080;
      6'd15: e = 16'h4C04;
      6'd16: e = 16'hD03C;
      6'd17: e = 16'hD6C0;
      6'd18: e = 16'h5512;
      6'd19: e = 16'h5608;
      6'd20: e = 16'h96F6;
      6'd21: e = 16'h7307;
      6'd22: e = 16'h761F;
      6'd23: e = 16'h94C0;
      6'd24: e = 16'hBA60;
      6'd25: e = 16'hD500;
      6'd26: e = 16'hDE10;
      6'd27: e = 16'hE460;
      6'd28: e = 16'hFA7D;
      6'd29: e = 16'h0A01;
      6'd30: e = 16'h0CBC;
      default: e = 16'h0000;
    endcase
    return cfg_entry_t'(e);
  endfunction

endpackage

// File: rtl/hdmi_cfg_if.sv
// Byte-write request channel between the configuration sequencer (master)
// and the I2C engine (slave): req held until a one-cycle done/nack pulse.
interface hdmi_cfg_if;
  logic       i2c_req;
  logic [7:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_data;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_dev, i2c_reg, i2c_data,
    input  i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_dev, i2c_reg, i2c_data,
    output i2c_done, i2c_nack
  );
endinterface

// File: rtl/hdmi_cfg_rom.sv
// Registered lookup of the default register table; entry valid one cycle
// after idx is presented, no backpressure.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] idx,
  output cfg_entry_t entry
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) entry <= '0;
    else          entry <= cfg_table(idx);
  end

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// Walks the HDMI transmitter register table, one I2C write per entry with NACK retry.
// Optional HDMI_CFG_HPD_EN: a hdmi_tx_int rising edge re-runs the table once idle.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int         PWRUP_CYCLES = 1_000_000,
  parameter int         GAP_CYCLES   = 5_000,
  parameter int         RETRY_MAX    = 3,
  parameter int         NUM_ENTRIES  = ADV7513_ENTRIES,
  parameter logic [7:0] DEV_ADDR     = 8'h72
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        hdmi_tx_int,
  hdmi_cfg_if.master  i2c,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [5:0]  cfg_index
);

  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  localparam logic [CW-1:0] PWR_LAST   = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);
  localparam logic [5:0]    LAST_IDX   = 6'(NUM_ENTRIES - 1);

  cfg_state_t    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic          req_q;
  logic [7:0]    reg_q;
  logic [7:0]    data_q;
  cfg_entry_t    rom_q;
  logic          idle;
  logic          restart;

  hdmi_cfg_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .idx     (cfg_index),
    .entry   (rom_q)
  );

  assign idle = (state == DONE) || (state == ERROR);

`ifdef HDMI_CFG_HPD_EN
  logic [1:0] hpd_sync;
  logic       hpd_prev;
  logic       hpd_pend;

  // An edge seen while busy stays pending until the table finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpd_sync <= 2'b00;
      hpd_prev <= 1'b0;
      hpd_pend <= 1'b0;
    end else begin
      hpd_sync <= {hpd_sync[0], hdmi_tx_int};
      hpd_prev <= hpd_sync[1];
      if (hpd_sync[1] && !hpd_prev) hpd_pend <= 1'b1;
      else if (restart)             hpd_pend <= 1'b0;
    end
  end

  assign restart = idle && (start || hpd_pend);
`else
  logic unused_hpd;
  assign unused_hpd = hdmi_tx_int;
  assign restart    = idle && start;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_PWR;
      cnt       <= PWR_LAST;
      retry     <= '0;
      cfg_index <= '0;
      req_q     <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      case (state)
        WAIT_PWR: begin
          if (cnt == '0) state <= LOAD;
          else           cnt   <= cnt - CW'(1);
        end
        LOAD: begin
          retry <= '0;
          state <= ISSUE;
        end
        // ROM output for cfg_index is valid here, whether arriving from LOAD or GAP.
        ISSUE: begin
          reg_q  <= rom_q.reg_addr;
          data_q <= rom_q.reg_data;
          req_q  <= 1'b1;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i2c.i2c_done) begin
            req_q <= 1'b0;
            if (!i2c.i2c_nack) begin
              if (cfg_index == LAST_IDX) begin
                state    <= DONE;
                cfg_done <= 1'b1;
                cfg_busy <= 1'b0;
              end else begin
                cfg_index <= cfg_index + 6'd1;
                state     <= LOAD;
              end
            end else if (retry == RETRY_LAST) begin
              state     <= ERROR;
              cfg_error <= 1'b1;
              cfg_busy  <= 1'b0;
            end else begin
              retry <= retry + RW'(1);
              cnt   <= GAP_LAST;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == '0) state <= ISSUE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE, ERROR: begin
          if (restart) begin
            cfg_index <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            cfg_busy  <= 1'b1;
            cnt       <= GAP_LAST;
            state     <= WAIT_PWR;
          end
        end
        default: state <= WAIT_PWR;
      endcase
    end
  end

  assign i2c.i2c_req  = req_q;
  assign i2c.i2c_dev  = DEV_ADDR;
  assign i2c.i2c_reg  = reg_q;
  assign i2c.i2c_data = data_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench for hdmi_cfg_sequencer with a behavioural I2C engine that
// acknowledges each request after 20 cycles and NACKs a chosen register on demand.
module tb_hdmi_cfg_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       hdmi_tx_int = 1'b0;
  logic       cfg_busy, cfg_done, cfg_error;
  logic [5:0] cfg_index;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_tab [31];
  logic [15:0] logq [$];
  logic [7:0]  nack_reg = 8'h00;
  int          nack_left = 0;
  int          acnt = 0;
  int          neg_cyc = 0;
  int          done_cyc = 0;
  int          min_gap = 100000;
  bit          last_nack = 1'b0;

  hdmi_cfg_if i2c ();

  hdmi_cfg_sequencer #(
    .PWRUP_CYCLES (100),
    .GAP_CYCLES   (10),
    .RETRY_MAX    (3),
    .NUM_ENTRIES  (31),
    .DEV_ADDR     (8'h72)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .hdmi_tx_int (hdmi_tx_int),
    .i2c         (i2c),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .cfg_index   (cfg_index)
  );

  initial forever #5 clk = ~clk;

  // Engine model: counts negedges with req high, pulses done on the 20th.
  initial begin
    i2c.i2c_done = 1'b0;
    i2c.i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      neg_cyc++;
      i2c.i2c_done = 1'b0;
      i2c.i2c_nack = 1'b0;
      if (i2c.i2c_req === 1'b1) begin
        if (acnt == 0 && last_nack) begin
          if (neg_cyc - done_cyc - 1 < min_gap) min_gap = neg_cyc - done_cyc - 1;
        end
        acnt++;
        if (acnt == 20) begin
          logq.push_back({i2c.i2c_reg, i2c.i2c_data});
          i2c.i2c_done = 1'b1;
          if (i2c.i2c_reg == nack_reg && nack_left > 0) begin
            i2c.i2c_nack = 1'b1;
            nack_left--;
            last_nack = 1'b1;
          end else begin
            last_nack = 1'b0;
          end
          done_cyc = neg_cyc;
          acnt = 0;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i2c.i2c_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fin(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1 || cfg_error === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    logq.delete();
    last_nack = 1'b0;
    min_gap = 100000;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int hi;
    bit ok;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (i2c.i2c_req !== 1'b0)   begin fails++; $display("FAIL rst_req got %b want 0", i2c.i2c_req); end
    tests++; if (i2c.i2c_reg !== 8'h00)  begin fails++; $display("FAIL rst_reg got %h want 00", i2c.i2c_reg); end
    tests++; if (i2c.i2c_data !== 8'h00) begin fails++; $display("FAIL rst_data got %h want 00", i2c.i2c_data); end
    tests++; if (cfg_busy !== 1'b1)      begin fails++; $display("FAIL rst_busy got %b want 1", cfg_busy); end
    tests++; if (cfg_done !== 1'b0)      begin fails++; $display("FAIL rst_done got %b want 0", cfg_done); end
    tests++; if (cfg_error !== 1'b0)     begin fails++; $display("FAIL rst_error got %b want 0", cfg_error); end
    tests++; if (cfg_index !== 6'd0)     begin fails++; $display("FAIL rst_index got %0d want 0", cfg_index); end
    logq.delete();
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i2c.i2c_req !== 1'b0) hi++;
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL pwrup_quiet req-high cycles %0d want 0", hi); end
    wait_req(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL first_req not seen within 110 cycles"); end
    tests++; if (i2c.i2c_reg !== 8'h41)  begin fails++; $display("FAIL first_reg got %h want 41", i2c.i2c_reg); end
    tests++; if (i2c.i2c_data !== 8'h10) begin fails++; $display("FAIL first_data got %h want 10", i2c.i2c_data); end
    tests++; if (i2c.i2c_dev !== 8'h72)  begin fails++; $display("FAIL dev got %h want 72", i2c.i2c_dev); end
  endtask

  task automatic test_all_ack();
    bit ok;
    wait_fin(3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL all_ack timeout busy=%b", cfg_busy); end
    tests++; if (logq.size() != 31) begin fails++; $display("FAIL all_ack count got %0d want 31", logq.size()); end
    for (int i = 0; i < 31; i++) begin
      tests++;
      if (i >= logq.size() || logq[i] !== exp_tab[i]) begin
        fails++;
        $display("FAIL all_ack entry %0d got %h want %h", i, (i < logq.size()) ? logq[i] : 16'hxxxx, exp_tab[i]);
      end
    end
    tests++; if (cfg_done !== 1'b1)   begin fails++; $display("FAIL all_ack done got %b want 1", cfg_done); end
    tests++; if (cfg_busy !== 1'b0)   begin fails++; $display("FAIL all_ack busy got %b want 0", cfg_busy); end
    tests++; if (cfg_error !== 1'b0)  begin fails++; $display("FAIL all_ack error got %b want 0", cfg_error); end
    tests++; if (cfg_index !== 6'd30) begin fails++; $display("FAIL all_ack index got %0d want 30", cfg_index); end
  endtask

  task automatic test_nack_retry();
    bit ok;
    int n3;
    nack_reg = 8'h9C;
    nack_left = 2;
    do_reset();
    wait_fin(3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL retry timeout"); end
    n3 = 0;
    foreach (logq[i]) if (logq[i] === 16'h9C30) n3++;
    tests++; if (n3 != 3)           begin fails++; $display("FAIL retry entry3 sends got %0d want 3", n3); end
    tests++; if (logq.size() != 33) begin fails++; $display("FAIL retry total got %0d want 33", logq.size()); end
    tests++; if (min_gap < 10)      begin fails++; $display("FAIL retry gap got %0d want >=10", min_gap); end
    tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL retry done got %b want 1", cfg_done); end
    tests++; if (cfg_error !== 1'b0) begin fails++; $display("FAIL retry error got %b want 0", cfg_error); end
  endtask

  task automatic test_nack_error();
    bit ok;
    int hi;
    nack_reg = 8'h9C;
    nack_left = 3;
    do_reset();
    wait_fin(3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL err timeout"); end
    repeat (2) @(negedge clk);
    tests++; if (cfg_error !== 1'b1)   begin fails++; $display("FAIL err flag got %b want 1", cfg_error); end
    tests++; if (cfg_done !== 1'b0)    begin fails++; $display("FAIL err done got %b want 0", cfg_done); end
    tests++; if (cfg_busy !== 1'b0)    begin fails++; $display("FAIL err busy got %b want 0", cfg_busy); end
    tests++; if (cfg_index !== 6'd3)   begin fails++; $display("FAIL err index got %0d want 3", cfg_index); end
    tests++; if (i2c.i2c_req !== 1'b0) begin fails++; $display("FAIL err req got %b want 0", i2c.i2c_req); end
    tests++; if (logq.size() != 6)     begin fails++; $display("FAIL err sends got %0d want 6", logq.size()); end
    logq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i2c.i2c_req !== 1'b0) hi++;
    end
    tests++; if (hi != 0)          begin fails++; $display("FAIL restart_wait req-high cycles %0d want 0", hi); end
    tests++; if (cfg_busy !== 1'b1) begin fails++; $display("FAIL restart busy got %b want 1", cfg_busy); end
    wait_fin(3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL restart timeout"); end
    tests++; if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      fails++; $display("FAIL restart flags done=%b error=%b want 1/0", cfg_done, cfg_error);
    end
    tests++; if (logq.size() != 31) begin fails++; $display("FAIL restart sends got %0d want 31", logq.size()); end
    tests++; if (logq.size() == 0 || logq[0] !== 16'h4110) begin fails++; $display("FAIL restart first entry wrong want 4110"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int hi;
    nack_left = 0;
    do_reset();
    wait_req(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid no req before reset"); end
    repeat (5) @(negedge clk);
    tests++; if (i2c.i2c_req !== 1'b1) begin fails++; $display("FAIL mid precondition req got %b want 1", i2c.i2c_req); end
    #1 reset_n = 1'b0;
    #1;
    tests++; if (i2c.i2c_req !== 1'b0) begin fails++; $display("FAIL mid async req got %b want 0", i2c.i2c_req); end
    tests++; if (cfg_busy !== 1'b1)    begin fails++; $display("FAIL mid busy got %b want 1", cfg_busy); end
    @(negedge clk);
    logq.delete();
    last_nack = 1'b0;
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i2c.i2c_req !== 1'b0) hi++;
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL mid pwrup req-high cycles %0d want 0", hi); end
    wait_fin(3000, ok);
    tests++; if (!ok || cfg_done !== 1'b1) begin fails++; $display("FAIL mid resume done got %b want 1", cfg_done); end
    tests++; if (logq.size() != 31) begin fails++; $display("FAIL mid sends got %0d want 31", logq.size()); end
  endtask

  task automatic test_hpd();
    bit ok;
    logq.delete();
    @(negedge clk);
    hdmi_tx_int = 1'b1;
    repeat (3) @(negedge clk);
    hdmi_tx_int = 1'b0;
`ifdef HDMI_CFG_HPD_EN
    wait_req(500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL hpd no rerun req"); end
    wait_fin(3000, ok);
    tests++; if (!ok || cfg_done !== 1'b1) begin fails++; $display("FAIL hpd rerun done got %b want 1", cfg_done); end
    tests++; if (logq.size() != 31) begin fails++; $display("FAIL hpd sends got %0d want 31", logq.size()); end
`else
    wait_req(500, ok);
    tests++; if (ok) begin fails++; $display("FAIL hpd_off req got 1 want 0"); end
    tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL hpd_off done got %b want 1", cfg_done); end
    tests++; if (logq.size() != 0)  begin fails++; $display("FAIL hpd_off sends got %0d want 0", logq.size()); end
`endif
  endtask

  initial begin
    exp_tab = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
                16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'h1846, 16'hAF06,
                16'h4080, 16'h4C04, 16'hD03C, 16'hD6C0, 16'h5512, 16'h5608, 16'h96F6,
                16'h7307, 16'h761F, 16'h94C0, 16'hBA60, 16'hD500, 16'hDE10, 16'hE460,
                16'hFA7D, 16'h0A01, 16'h0CBC};
    test_reset();
    test_all_ack();
    test_nack_retry();
    test_nack_error();
    test_reset_mid();
    test_hpd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
